// File: rtl/axi4_burst_ram.sv
// AXI4 slave memory with FIXED/INCR/WRAP bursts, narrow transfers and byte strobes.
// Independent write and read channel FSMs share one word array (read-before-write on collisions).
module axi4_burst_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    io_axi_aw_valid,
  output logic                    io_axi_aw_ready,
  input  logic [ADDR_WIDTH-1:0]   io_axi_aw_payload_addr,
  input  logic [7:0]              io_axi_aw_payload_len,
  input  logic [2:0]              io_axi_aw_payload_size,
  input  logic [1:0]              io_axi_aw_payload_burst,
  input  logic                    io_axi_w_valid,
  output logic                    io_axi_w_ready,
  input  logic [DATA_WIDTH-1:0]   io_axi_w_payload_data,
  input  logic [DATA_WIDTH/8-1:0] io_axi_w_payload_strb,
  input  logic                    io_axi_w_payload_last,
  output logic                    io_axi_b_valid,
  input  logic                    io_axi_b_ready,
  output logic [1:0]              io_axi_b_payload_resp,
  input  logic                    io_axi_ar_valid,
  output logic                    io_axi_ar_ready,
  input  logic [ADDR_WIDTH-1:0]   io_axi_ar_payload_addr,
  input  logic [7:0]              io_axi_ar_payload_len,
  input  logic [2:0]              io_axi_ar_payload_size,
  input  logic [1:0]              io_axi_ar_payload_burst,
  output logic                    io_axi_r_valid,
  input  logic                    io_axi_r_ready,
  output logic [DATA_WIDTH-1:0]   io_axi_r_payload_data,
  output logic [1:0]              io_axi_r_payload_resp,
  output logic                    io_axi_r_payload_last
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int IDXW  = $clog2(DEPTH);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic [ADDR_WIDTH-1:0] nextAddr(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [7:0] len,
                                                     input logic [2:0] size,
                                                     input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] span, bound, inc;
    span  = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    bound = a & ~(span - ADDR_WIDTH'(1));
    inc   = a + (ADDR_WIDTH'(1) << size);
    if (burst == BURST_FIXED) return a;
    if (burst == BURST_WRAP && inc == bound + span) return bound;
    return inc;
  endfunction

  function automatic logic outOfRange(input logic [ADDR_WIDTH-1:0] a);
    return (a >> OFFS) >= ADDR_WIDTH'(DEPTH);
  endfunction

  function automatic logic burstError(input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
    logic badWrapLen;
    badWrapLen = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (size > 3'(OFFS)) || (burst == 2'b11) || (burst == BURST_WRAP && badWrapLen);
  endfunction

  function automatic logic [IDXW-1:0] memIndex(input logic [ADDR_WIDTH-1:0] a);
    return IDXW'(a >> OFFS);
  endfunction

  logic [1:0]            wState;
  logic [ADDR_WIDTH-1:0] wAddr;
  logic [7:0]            wLen, wCount;
  logic [2:0]            wSize;
  logic [1:0]            wBurst;
  logic                  wErr, wBurstErr;
  logic                  awFire, wFire, bFire, wLastBeat, wBeatBad, wBeatErr;

  assign awFire    = io_axi_aw_valid && io_axi_aw_ready;
  assign wFire     = io_axi_w_valid && io_axi_w_ready;
  assign bFire     = io_axi_b_valid && io_axi_b_ready;
  assign wLastBeat = (wCount == wLen);
  assign wBeatBad  = wBurstErr || outOfRange(wAddr);
  assign wBeatErr  = wBeatBad || (io_axi_w_payload_last != wLastBeat);

  // Write channel: the burst ends on the beat count alone, a wrong w_last only poisons the response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wState                <= W_IDLE;
      wAddr                 <= '0;
      wLen                  <= '0;
      wSize                 <= '0;
      wBurst                <= '0;
      wCount                <= '0;
      wErr                  <= 1'b0;
      wBurstErr             <= 1'b0;
      io_axi_aw_ready       <= 1'b0;
      io_axi_w_ready        <= 1'b0;
      io_axi_b_valid        <= 1'b0;
      io_axi_b_payload_resp <= RESP_OKAY;
    end else begin
      case (wState)
        W_IDLE: begin
          io_axi_aw_ready <= 1'b1;
          if (awFire) begin
            wAddr           <= io_axi_aw_payload_addr;
            wLen            <= io_axi_aw_payload_len;
            wSize           <= io_axi_aw_payload_size;
            wBurst          <= io_axi_aw_payload_burst;
            wCount          <= '0;
            wErr            <= 1'b0;
            wBurstErr       <= burstError(io_axi_aw_payload_len, io_axi_aw_payload_size,
                                          io_axi_aw_payload_burst);
            io_axi_aw_ready <= 1'b0;
            io_axi_w_ready  <= 1'b1;
            wState          <= W_DATA;
          end
        end
        W_DATA: begin
          if (wFire) begin
            wCount <= wCount + 8'd1;
            wAddr  <= nextAddr(wAddr, wLen, wSize, wBurst);
            wErr   <= wErr || wBeatErr;
            if (wLastBeat) begin
              io_axi_w_ready        <= 1'b0;
              io_axi_b_valid        <= 1'b1;
              io_axi_b_payload_resp <= (wErr || wBeatErr) ? RESP_SLVERR : RESP_OKAY;
              wState                <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bFire) begin
            io_axi_b_valid        <= 1'b0;
            io_axi_b_payload_resp <= RESP_OKAY;
            io_axi_aw_ready       <= 1'b1;
            wState                <= W_IDLE;
          end
        end
        default: wState <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wFire && !wBeatBad) begin
      for (int i = 0; i < BYTES; i++) begin
        if (io_axi_w_payload_strb[i])
          mem[memIndex(wAddr)][8*i +: 8] <= io_axi_w_payload_data[8*i +: 8];
      end
    end
  end

  logic [0:0]            rState;
  logic [ADDR_WIDTH-1:0] rAddr, rNextAddr, rdAddr;
  logic [7:0]            rLen, rCount;
  logic [2:0]            rSize;
  logic [1:0]            rBurst;
  logic                  rBurstErr, arBurstErr, arFire, rFire, rdBad;

  assign arFire     = io_axi_ar_valid && io_axi_ar_ready;
  assign rFire      = io_axi_r_valid && io_axi_r_ready;
  assign arBurstErr = burstError(io_axi_ar_payload_len, io_axi_ar_payload_size,
                                 io_axi_ar_payload_burst);
  assign rNextAddr  = nextAddr(rAddr, rLen, rSize, rBurst);
  assign rdAddr     = (rState == R_IDLE) ? io_axi_ar_payload_addr : rNextAddr;
  assign rdBad      = ((rState == R_IDLE) ? arBurstErr : rBurstErr) || outOfRange(rdAddr);

  // Read channel: the beat after the one being handed over is fetched on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rState                <= R_IDLE;
      rAddr                 <= '0;
      rLen                  <= '0;
      rSize                 <= '0;
      rBurst                <= '0;
      rCount                <= '0;
      rBurstErr             <= 1'b0;
      io_axi_ar_ready       <= 1'b0;
      io_axi_r_valid        <= 1'b0;
      io_axi_r_payload_data <= '0;
      io_axi_r_payload_resp <= RESP_OKAY;
      io_axi_r_payload_last <= 1'b0;
    end else begin
      case (rState)
        R_IDLE: begin
          io_axi_ar_ready <= 1'b1;
          if (arFire) begin
            rAddr                 <= io_axi_ar_payload_addr;
            rLen                  <= io_axi_ar_payload_len;
            rSize                 <= io_axi_ar_payload_size;
            rBurst                <= io_axi_ar_payload_burst;
            rCount                <= '0;
            rBurstErr             <= arBurstErr;
            io_axi_ar_ready       <= 1'b0;
            io_axi_r_valid        <= 1'b1;
            io_axi_r_payload_data <= rdBad ? '0 : mem[memIndex(rdAddr)];
            io_axi_r_payload_resp <= rdBad ? RESP_SLVERR : RESP_OKAY;
            io_axi_r_payload_last <= (io_axi_ar_payload_len == 8'd0);
            rState                <= R_DATA;
          end
        end
        R_DATA: begin
          if (rFire) begin
            if (io_axi_r_payload_last) begin
              io_axi_r_valid        <= 1'b0;
              io_axi_r_payload_last <= 1'b0;
              io_axi_ar_ready       <= 1'b1;
              rState                <= R_IDLE;
            end else begin
              rAddr                 <= rNextAddr;
              rCount                <= rCount + 8'd1;
              io_axi_r_payload_data <= rdBad ? '0 : mem[memIndex(rdAddr)];
              io_axi_r_payload_resp <= rdBad ? RESP_SLVERR : RESP_OKAY;
              io_axi_r_payload_last <= ((rCount + 8'd1) == rLen);
            end
          end
        end
        default: rState <= R_IDLE;
      endcase
    end
  end

endmodule
